// File: rtl/bsg_fifo_replay_pkg.sv
// Shared helpers for the store-and-forward replay FIFO: depth and wrap-aware pointer arithmetic.
package bsg_fifo_replay_pkg;

    function automatic int unsigned depth_f(input int unsigned lg_size);
        return 32'd1 << lg_size;
    endfunction

    // Modular difference a - b over ptr_bits bits (pointers carry one extra wrap bit).
    function automatic int unsigned ptr_diff(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned ptr_bits);
        return (a - b) & ((32'd1 << ptr_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple-dual-port storage: synchronous write, asynchronous read, no reset on the array.
module bsg_mem_1r1w #(
    parameter int unsigned width_p  = 8,
    parameter int unsigned lg_els_p = 2
) (
    input  logic                clk_i,
    input  logic                w_v_i,
    input  logic [lg_els_p-1:0] w_addr_i,
    input  logic [width_p-1:0]  w_data_i,
    input  logic [lg_els_p-1:0] r_addr_i,
    output logic [width_p-1:0]  r_data_o
);

    localparam int unsigned els_lp = 32'd1 << lg_els_p;

    logic [width_p-1:0] mem_r [els_lp];

    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_fifo_1r1w_store_and_forward_replay.sv
// Transactional 1R1W FIFO: writes are invisible until committed (or dropped),
// reads stay resident until committed (or rewound and replayed).
module bsg_fifo_1r1w_store_and_forward_replay
    import bsg_fifo_replay_pkg::*;
#(
    parameter int unsigned width_p            = 8,
    parameter int unsigned lg_size_p          = 2,
    parameter int unsigned ready_THEN_valid_p = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enq_commit_i,
    input  logic                 enq_drop_i,
    input  logic [width_p-1:0]   data_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic [width_p-1:0]   data_o,
    output logic                 v_o,
    input  logic                 yumi_i,
    input  logic                 deq_commit_i,
    input  logic                 deq_rewind_i,
    output logic [lg_size_p:0]   occupancy_o
);

    localparam int unsigned ptr_w_lp = lg_size_p + 1;
    localparam int unsigned depth_lp = depth_f(lg_size_p);

    logic [ptr_w_lp-1:0] w_r, wc_r, r_r, rc_r;
    logic [ptr_w_lp-1:0] w_next, r_next;
    logic                enq_fire;
    int unsigned         occ;

    assign occ         = ptr_diff(32'(w_r), 32'(rc_r), ptr_w_lp);
    assign occupancy_o = ptr_w_lp'(occ);
    assign ready_o     = (occ != depth_lp);
    assign v_o         = (r_r != wc_r);
    assign enq_fire    = v_i & ready_o;
    assign w_next      = w_r + ptr_w_lp'(enq_fire);
    assign r_next      = r_r + ptr_w_lp'(yumi_i);

    // Pointer state; drop and rewind win over their respective commits.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_r  <= '0;
            wc_r <= '0;
            r_r  <= '0;
            rc_r <= '0;
        end else begin
            if (enq_drop_i) begin
                w_r <= wc_r;
            end else begin
                w_r <= w_next;
                if (enq_commit_i) wc_r <= w_next;
            end
            if (deq_rewind_i) begin
                r_r <= rc_r;
            end else begin
                r_r <= r_next;
                if (deq_commit_i) rc_r <= r_next;
            end
        end
    end

    bsg_mem_1r1w #(
        .width_p (width_p),
        .lg_els_p(lg_size_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (enq_fire),
        .w_addr_i(w_r[lg_size_p-1:0]),
        .w_data_i(data_i),
        .r_addr_i(r_r[lg_size_p-1:0]),
        .r_data_o(data_o)
    );

    a_enq_ctl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enq_commit_i && enq_drop_i));
    a_deq_ctl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(deq_commit_i && deq_rewind_i));
    a_yumi: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !yumi_i || v_o);
    a_rtv: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (ready_THEN_valid_p == 0) || !v_i || ready_o);
    // rc <= r <= wc <= w in circular order, never more than depth outstanding.
    a_order: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (ptr_diff(32'(r_r), 32'(rc_r), ptr_w_lp) <= ptr_diff(32'(wc_r), 32'(rc_r), ptr_w_lp)) &&
        (ptr_diff(32'(wc_r), 32'(rc_r), ptr_w_lp) <= occ) &&
        (occ <= depth_lp));

endmodule

// File: tb/tb_bsg_fifo_1r1w_store_and_forward_replay.sv
// Scoreboard bench: a queue-level model of the transactional FIFO predicts each cycle's outputs.
module tb_bsg_fifo_1r1w_store_and_forward_replay;

    localparam int unsigned W     = 16;
    localparam int unsigned LG    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enq_commit = 1'b0, enq_drop = 1'b0, v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_o, v_o;
    logic [W-1:0]  data_o;
    logic          yumi = 1'b0, deq_commit = 1'b0, deq_rewind = 1'b0;
    logic [LG:0]   occupancy_o;

    bsg_fifo_1r1w_store_and_forward_replay #(
        .width_p(W), .lg_size_p(LG), .ready_THEN_valid_p(0)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .enq_commit_i(enq_commit), .enq_drop_i(enq_drop),
        .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi),
        .deq_commit_i(deq_commit), .deq_rewind_i(deq_rewind),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         rdy;
        int           occ;
        logic [W-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [W-1:0]  spec_q[$];   // written, not yet committed
    logic [W-1:0]  vis_q[$];    // committed, not yet read
    logic [W-1:0]  rd_q[$];     // read, not yet released
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    // Monitor: compares DUT outputs against the prediction pushed for this cycle.
    always @(negedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("v_o", int'(v_o), int'(mon_e.v));
            chk("ready_o", int'(ready_o), int'(mon_e.rdy));
            chk("occupancy_o", int'(occupancy_o), mon_e.occ);
            if (mon_e.v) chk("data_o", int'(data_o), int'(mon_e.d));
        end
    end

    // One cycle: predict current outputs, drive inputs, advance the model past the next edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic ec, input logic ed,
                        input logic y, input logic dc, input logic dr);
        exp_t e;
        int   occ;
        logic ye, fire;
        @(negedge clk);
        occ   = spec_q.size() + vis_q.size() + rd_q.size();
        e.v   = (vis_q.size() > 0);
        e.rdy = (occ != DEPTH);
        e.occ = occ;
        e.d   = e.v ? vis_q[0] : '0;
        exp_q.push_back(e);
        ye   = y && e.v;
        fire = v && e.rdy;
        v_i = v; data_i = d; enq_commit = ec; enq_drop = ed;
        yumi = ye; deq_commit = dc; deq_rewind = dr;
        if (ye) rd_q.push_back(vis_q.pop_front());
        if (dr) begin
            vis_q = {rd_q, vis_q};
            rd_q.delete();
        end else if (dc) begin
            rd_q.delete();
        end
        if (fire) spec_q.push_back(d);
        if (ed) spec_q.delete();
        else if (ec) begin
            vis_q = {vis_q, spec_q};
            spec_q.delete();
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [W-1:0] d, input logic ec);
        step(1'b1, d, ec, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic dc);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, dc, 1'b0);
    endtask

    initial begin
        #12;
        @(negedge clk) reset_n = 1'b1;
        idle();

        // Commit on the third write; nothing visible until the cycle after.
        wr(16'hA0A0, 1'b0); wr(16'hB1B1, 1'b0); wr(16'hC2C2, 1'b1);
        idle();
        rd(1'b0); rd(1'b0); rd(1'b1);
        idle();

        // Two committed, two speculative, then drop.
        wr(16'h1111, 1'b0); wr(16'h2222, 1'b1); wr(16'h3333, 1'b0); wr(16'h4444, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        rd(1'b0); rd(1'b1);
        idle();

        // Fill, read all without releasing, rewind, replay and release.
        wr(16'h5005, 1'b0); wr(16'h6006, 1'b0); wr(16'h7007, 1'b0); wr(16'h8008, 1'b1);
        rd(1'b0); rd(1'b0); rd(1'b0); rd(1'b0);
        idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rd(1'b0); rd(1'b0); rd(1'b0); rd(1'b1);
        idle();

        // Streaming with commits on both sides every cycle; pointers wrap.
        for (int i = 0; i < 3 * DEPTH; i++)
            step(1'b1, W'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2 * DEPTH; i++) rd(1'b1);
        idle();

        // Async reset mid-cycle with committed and speculative entries held.
        wr(16'hAAAA, 1'b0); wr(16'hBBBB, 1'b1); wr(16'hCCCC, 1'b0); wr(16'hDDDD, 1'b0);
        @(posedge clk);
        #2;
        v_i = 1'b0; enq_commit = 1'b0; enq_drop = 1'b0;
        yumi = 1'b0; deq_commit = 1'b0; deq_rewind = 1'b0;
        chk("pre_reset_occupancy", int'(occupancy_o), 4);
        reset_n = 1'b0;
        #1;
        chk("async_reset_v_o", int'(v_o), 0);
        chk("async_reset_ready_o", int'(ready_o), 1);
        chk("async_reset_occupancy", int'(occupancy_o), 0);
        spec_q.delete(); vis_q.delete(); rd_q.delete();
        @(negedge clk) reset_n = 1'b1;
        idle();

        // Randomized traffic with legal control combinations.
        for (int i = 0; i < 600; i++) begin
            logic ed, ec, dr, dc;
            ed = ($urandom_range(99) < 5);
            ec = !ed && ($urandom_range(99) < 25);
            dr = ($urandom_range(99) < 5);
            dc = !dr && ($urandom_range(99) < 25);
            step(($urandom_range(99) < 60), W'($urandom), ec, ed,
                 ($urandom_range(99) < 50), dc, dr);
        end
        idle();

        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
